// File: rtl/uart_master_slave_pkg.sv
// Shared constants, status layout and command-engine state for the UART
// host-link bridge (serial command master plus CPU-side slave port).
package uart_master_slave_pkg;

    localparam logic [7:0] CMD_WRITE   = 8'h57;
    localparam logic [7:0] CMD_READ    = 8'h52;
    localparam logic [7:0] CMD_RESET   = 8'h58;
    localparam logic [7:0] CMD_DELIVER = 8'h44;
    localparam logic [7:0] REPLY_OK    = 8'h4B;

    localparam int STAT_RX_VALID = 0;
    localparam int STAT_TX_READY = 1;
    localparam int STAT_OVERRUN  = 2;

    // Last count value of the system-reset pulse (pulse lasts this + 1 clocks).
    localparam logic [1:0] RESET_PULSE_LAST = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_AH,
        ST_GET_AL,
        ST_GET_D,
        ST_BUS,
        ST_RESP
    } eng_state_e;

    function automatic int baud_div(input int sys_freq, input int baudrate);
        return sys_freq / baudrate;
    endfunction

endpackage

// File: rtl/uart_master_slave_phy.sv
// 8N1 serial PHY: baud timing, double-flopped receiver with start-bit recheck
// and stop-bit validation, and a transmitter with a ready/valid byte handshake.
module uart_phy
    import uart_master_slave_pkg::*;
#(
    parameter int BAUDRATE = 1152000,
    parameter int SYS_FREQ = 25000000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rx,
    output logic       o_tx,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready
);

    localparam int DIV   = baud_div(SYS_FREQ, BAUDRATE);
    localparam int CNT_W = $clog2(DIV + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic {TX_IDLE, TX_BUSY} tx_state_e;

    rx_state_e        rx_state_q;
    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    logic [CNT_W-1:0] rx_cnt_q;
    logic [2:0]       rx_bit_q;
    logic [7:0]       rx_shift_q;
    logic             rx_valid_q;

    tx_state_e        tx_state_q;
    logic [CNT_W-1:0] tx_cnt_q;
    logic [3:0]       tx_left_q;
    logic [8:0]       tx_shift_q;
    logic             tx_q;

    // NOTE: reset is sampled on the clock edge, so it sits inside the clocked branch, not the sensitivity list.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_meta_q  <= i_rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_valid_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        rx_state_q <= RX_START;
                        rx_cnt_q   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 1'b1;
                        if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_valid_q <= rx_sync_q;
                        rx_state_q <= RX_IDLE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // Frame is loaded as start bit on the line plus {stop, data} in the shifter.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_left_q  <= '0;
            tx_shift_q <= '1;
            tx_q       <= 1'b1;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (i_tx_valid) begin
                        tx_q       <= 1'b0;
                        tx_shift_q <= {1'b1, i_tx_data};
                        tx_left_q  <= 4'd9;
                        tx_cnt_q   <= '0;
                        tx_state_q <= TX_BUSY;
                    end
                end
                TX_BUSY: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q <= '0;
                        if (tx_left_q == 4'd0) begin
                            tx_q       <= 1'b1;
                            tx_state_q <= TX_IDLE;
                        end else begin
                            tx_q       <= tx_shift_q[0];
                            tx_shift_q <= {1'b1, tx_shift_q[8:1]};
                            tx_left_q  <= tx_left_q - 1'b1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign o_rx_data  = rx_shift_q;
    assign o_rx_valid = rx_valid_q;
    assign o_tx       = tx_q;
    assign o_tx_ready = (tx_state_q == TX_IDLE);

endmodule

// File: rtl/uart_master_slave.sv
// Host-link bridge: serial W/R/X/D commands drive a memory master port and a
// CPU-visible RX register; the CPU slave port reads status/data and sends bytes.
module uart_master_slave
    import uart_master_slave_pkg::*;
#(
    parameter int BAUDRATE = 1152000,
    parameter int SYS_FREQ = 25000000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [7:0]  i_master_data,
    output logic [7:0]  o_master_data,
    output logic [15:0] o_master_addr,
    input  logic        i_master_ack,
    output logic        o_master_we,
    output logic        o_master_cs,
    input  logic [7:0]  i_slave_data,
    output logic [7:0]  o_slave_data,
    input  logic        i_slave_addr,
    output logic        o_slave_ack,
    input  logic        i_slave_we,
    input  logic        i_slave_cs,
    output logic        o_int,
    input  logic        i_uart_rx,
    output logic        o_uart_tx,
    output logic        o_reset
);

    logic [7:0] rx_byte;
    logic       rx_byte_valid;
    logic       phy_tx_ready;
    logic       tx_start;
    logic [7:0] tx_byte;

    eng_state_e  state_q;
    logic [7:0]  cmd_q;
    logic [7:0]  resp_q;
    logic [1:0]  rst_cnt_q;
    logic        master_cs_q, master_we_q, sys_reset_q;
    logic [15:0] master_addr_q;
    logic [7:0]  master_data_q;

    logic       rx_valid_q, rx_valid_d;
    logic       overrun_q, overrun_d;
    logic [7:0] rx_reg_q, rx_reg_d;
    logic       cs_prev_q, cs_prev_d;

    logic       slave_first, status_rd, data_rd, data_wr, deliver;
    logic       tx_ready, resp_send;
    logic [7:0] status;

    uart_phy #(
        .BAUDRATE (BAUDRATE),
        .SYS_FREQ (SYS_FREQ)
    ) u_phy (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_rx       (i_uart_rx),
        .o_tx       (o_uart_tx),
        .o_rx_data  (rx_byte),
        .o_rx_valid (rx_byte_valid),
        .i_tx_data  (tx_byte),
        .i_tx_valid (tx_start),
        .o_tx_ready (phy_tx_ready)
    );

    // The X command reuses BUS as its pulse-timing state; no bus request is made.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q       <= ST_IDLE;
            cmd_q         <= '0;
            resp_q        <= '0;
            rst_cnt_q     <= '0;
            master_cs_q   <= 1'b0;
            master_we_q   <= 1'b0;
            master_addr_q <= '0;
            master_data_q <= '0;
            sys_reset_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_byte_valid) begin
                        cmd_q <= rx_byte;
                        case (rx_byte)
                            CMD_WRITE, CMD_READ: state_q <= ST_GET_AH;
                            CMD_DELIVER:         state_q <= ST_GET_D;
                            CMD_RESET: begin
                                state_q     <= ST_BUS;
                                sys_reset_q <= 1'b1;
                                rst_cnt_q   <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_GET_AH: begin
                    if (rx_byte_valid) begin
                        master_addr_q[15:8] <= rx_byte;
                        state_q             <= ST_GET_AL;
                    end
                end
                ST_GET_AL: begin
                    if (rx_byte_valid) begin
                        master_addr_q[7:0] <= rx_byte;
                        if (cmd_q == CMD_WRITE) begin
                            state_q <= ST_GET_D;
                        end else begin
                            master_we_q <= 1'b0;
                            master_cs_q <= 1'b1;
                            state_q     <= ST_BUS;
                        end
                    end
                end
                ST_GET_D: begin
                    if (rx_byte_valid) begin
                        if (cmd_q == CMD_WRITE) begin
                            master_data_q <= rx_byte;
                            master_we_q   <= 1'b1;
                            master_cs_q   <= 1'b1;
                            state_q       <= ST_BUS;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_BUS: begin
                    if (cmd_q == CMD_RESET) begin
                        if (rst_cnt_q == RESET_PULSE_LAST) begin
                            sys_reset_q <= 1'b0;
                            state_q     <= ST_IDLE;
                        end else begin
                            rst_cnt_q <= rst_cnt_q + 1'b1;
                        end
                    end else if (i_master_ack) begin
                        master_cs_q <= 1'b0;
                        resp_q      <= (cmd_q == CMD_READ) ? i_master_data : REPLY_OK;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (phy_tx_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        slave_first = i_slave_cs && !cs_prev_q;
        status_rd   = slave_first && !i_slave_we && !i_slave_addr;
        data_rd     = slave_first && !i_slave_we && i_slave_addr;
        data_wr     = slave_first && i_slave_we && i_slave_addr;
        deliver     = (state_q == ST_GET_D) && (cmd_q == CMD_DELIVER) && rx_byte_valid;
        tx_ready    = phy_tx_ready && (state_q != ST_RESP);
        resp_send   = (state_q == ST_RESP) && phy_tx_ready;
        tx_start    = resp_send || (data_wr && tx_ready);
        tx_byte     = resp_send ? resp_q : i_slave_data;
        cs_prev_d   = i_slave_cs;

        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
        rx_reg_d   = rx_reg_q;
        if (status_rd) overrun_d = 1'b0;
        if (data_rd) rx_valid_d = 1'b0;
        // A byte consumed in the same cycle is not lost, so it is not an overrun.
        if (deliver) begin
            rx_reg_d   = rx_byte;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !data_rd) overrun_d = 1'b1;
        end

        status                = '0;
        status[STAT_RX_VALID] = rx_valid_q;
        status[STAT_TX_READY] = tx_ready;
        status[STAT_OVERRUN]  = overrun_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            rx_reg_q   <= '0;
            cs_prev_q  <= 1'b0;
        end else begin
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
            rx_reg_q   <= rx_reg_d;
            cs_prev_q  <= cs_prev_d;
        end
    end

    assign o_slave_ack   = i_slave_cs;
    assign o_slave_data  = i_slave_cs ? (i_slave_addr ? rx_reg_q : status) : 8'h00;
    assign o_int         = rx_valid_q;
    assign o_master_cs   = master_cs_q;
    assign o_master_we   = master_we_q;
    assign o_master_addr = master_addr_q;
    assign o_master_data = master_data_q;
    assign o_reset       = sys_reset_q;

endmodule

// File: tb/tb_uart_master_slave.sv
// Directed bench for uart_master_slave: serial commands, memory handshake,
// CPU slave port, system-reset pulse and reset abort, with hand-computed values.
module tb_uart_master_slave;

    localparam int BIT = 21;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [7:0]  i_master_data;
    logic [7:0]  o_master_data;
    logic [15:0] o_master_addr;
    logic        i_master_ack;
    logic        o_master_we;
    logic        o_master_cs;
    logic [7:0]  i_slave_data;
    logic [7:0]  o_slave_data;
    logic        i_slave_addr;
    logic        o_slave_ack;
    logic        i_slave_we;
    logic        i_slave_cs;
    logic        o_int;
    logic        i_uart_rx;
    logic        o_uart_tx;
    logic        o_reset;

    int vectors = 0;
    int miscompares = 0;

    always #5 i_clk = ~i_clk;

    uart_master_slave #(
        .BAUDRATE (1152000),
        .SYS_FREQ (25000000)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_master_data (i_master_data),
        .o_master_data (o_master_data),
        .o_master_addr (o_master_addr),
        .i_master_ack  (i_master_ack),
        .o_master_we   (o_master_we),
        .o_master_cs   (o_master_cs),
        .i_slave_data  (i_slave_data),
        .o_slave_data  (o_slave_data),
        .i_slave_addr  (i_slave_addr),
        .o_slave_ack   (o_slave_ack),
        .i_slave_we    (i_slave_we),
        .i_slave_cs    (i_slave_cs),
        .o_int         (o_int),
        .i_uart_rx     (i_uart_rx),
        .o_uart_tx     (o_uart_tx),
        .o_reset       (o_reset)
    );

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish within 3 ms");
        $fatal(1, "watchdog expired");
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        @(posedge i_clk); #1;
        i_uart_rx = 1'b0;
        repeat (BIT) @(posedge i_clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            i_uart_rx = b[i];
            repeat (BIT) @(posedge i_clk);
            #1;
        end
        i_uart_rx = stop_bit;
        repeat (BIT) @(posedge i_clk);
        #1;
        i_uart_rx = 1'b1;
        repeat (BIT) @(posedge i_clk);
        #1;
    endtask

    task automatic slave_read(input logic addr, output logic [7:0] data, output logic ack);
        @(posedge i_clk); #1;
        i_slave_cs = 1'b1; i_slave_we = 1'b0; i_slave_addr = addr;
        @(negedge i_clk);
        data = o_slave_data;
        ack  = o_slave_ack;
        @(posedge i_clk); #1;
        i_slave_cs = 1'b0; i_slave_addr = 1'b0;
    endtask

    task automatic slave_write(input logic addr, input logic [7:0] data);
        @(posedge i_clk); #1;
        i_slave_cs = 1'b1; i_slave_we = 1'b1; i_slave_addr = addr; i_slave_data = data;
        @(posedge i_clk); #1;
        i_slave_cs = 1'b0; i_slave_we = 1'b0; i_slave_addr = 1'b0;
    endtask

    task automatic wait_cs(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge i_clk);
            if (o_master_cs === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s_cs_timeout: o_master_cs never rose within 500 clocks", name);
        end
    endtask

    // Ack after three idle clocks; cs must hold during ack and drop on the next clock.
    task automatic ack_bus(input string name, input logic [7:0] rdata);
        repeat (3) @(posedge i_clk);
        #1;
        i_master_data = rdata;
        i_master_ack  = 1'b1;
        @(negedge i_clk);
        vectors++;
        if (o_master_cs !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_cs_during_ack: got %b expected 1", name, o_master_cs);
        end
        @(posedge i_clk); #1;
        i_master_ack  = 1'b0;
        i_master_data = 8'hFF;
        @(negedge i_clk);
        vectors++;
        if (o_master_cs !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_cs_after_ack: got %b expected 0", name, o_master_cs);
        end
    endtask

    task automatic capture_tx(input logic [7:0] exp, input string name);
        bit         found = 1'b0;
        bit         edge_ok = 1'b1;
        logic [9:0] frame = '0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge i_clk);
            if (o_uart_tx === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL %s_tx_start: no start bit within 3000 clocks", name);
        end else begin
            for (int off = 1; off <= BIT * 9 + BIT / 2; off++) begin
                @(negedge i_clk);
                if (off % BIT == BIT / 2) frame[off / BIT] = o_uart_tx;
                if (off == BIT - 1 && o_uart_tx !== 1'b0) edge_ok = 1'b0;
                if (off == BIT && o_uart_tx !== exp[0]) edge_ok = 1'b0;
            end
            vectors++;
            if (frame[8:1] !== exp) begin
                miscompares++;
                $display("FAIL %s_tx_byte: got %h expected %h", name, frame[8:1], exp);
            end
            vectors++;
            if (frame[0] !== 1'b0 || frame[9] !== 1'b1) begin
                miscompares++;
                $display("FAIL %s_tx_framing: start %b stop %b expected 0/1", name, frame[0], frame[9]);
            end
            vectors++;
            if (!edge_ok) begin
                miscompares++;
                $display("FAIL %s_tx_bit_period: start bit not exactly %0d clocks", name, BIT);
            end
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        i_slave_cs = 1'b1; i_slave_addr = 1'b0; i_slave_we = 1'b0;
        repeat (4) @(posedge i_clk);
        @(negedge i_clk);
        vectors++;
        if ({o_uart_tx, o_master_cs, o_master_we, o_reset, o_int} !== 5'b10000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got tx/cs/we/rst/int %b expected 10000",
                     {o_uart_tx, o_master_cs, o_master_we, o_reset, o_int});
        end
        vectors++;
        if ({o_master_addr, o_master_data} !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_bus: got addr %h data %h expected 0000/00", o_master_addr, o_master_data);
        end
        vectors++;
        if (o_slave_data !== 8'h02 || o_slave_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_status: got %h ack %b expected 02 ack 1", o_slave_data, o_slave_ack);
        end
        @(posedge i_clk); #1;
        i_slave_cs = 1'b0;
        i_reset = 1'b1;
        repeat (5) @(posedge i_clk);
        @(negedge i_clk);
        vectors++;
        if (o_slave_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_ack: got %b expected 0", o_slave_ack);
        end
    endtask

    task automatic test_write();
        send_byte(8'h57); send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB);
        wait_cs("write");
        vectors++;
        if ({o_master_we, o_master_addr, o_master_data} !== {1'b1, 16'h1234, 8'hAB}) begin
            miscompares++;
            $display("FAIL write_bus: got we %b addr %h data %h expected 1/1234/ab",
                     o_master_we, o_master_addr, o_master_data);
        end
        ack_bus("write", 8'h00);
        capture_tx(8'h4B, "write_reply");
    endtask

    task automatic test_read();
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h10);
        wait_cs("read");
        vectors++;
        if ({o_master_we, o_master_addr} !== {1'b0, 16'h0010}) begin
            miscompares++;
            $display("FAIL read_bus: got we %b addr %h expected 0/0010", o_master_we, o_master_addr);
        end
        ack_bus("read", 8'h5A);
        capture_tx(8'h5A, "read_reply");
    endtask

    task automatic test_deliver();
        logic [7:0] d;
        logic       a;
        send_byte(8'h44); send_byte(8'h41);
        @(negedge i_clk);
        vectors++;
        if (o_int !== 1'b1) begin
            miscompares++;
            $display("FAIL deliver_int: got %b expected 1", o_int);
        end
        slave_read(1'b0, d, a);
        vectors++;
        if (d !== 8'h03 || a !== 1'b1) begin
            miscompares++;
            $display("FAIL deliver_status: got %h ack %b expected 03 ack 1", d, a);
        end
        slave_read(1'b1, d, a);
        vectors++;
        if (d !== 8'h41) begin
            miscompares++;
            $display("FAIL deliver_data: got %h expected 41", d);
        end
        @(negedge i_clk);
        vectors++;
        if (o_int !== 1'b0) begin
            miscompares++;
            $display("FAIL deliver_int_clear: got %b expected 0", o_int);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] d;
        logic       a;
        send_byte(8'h44); send_byte(8'h11);
        send_byte(8'h44); send_byte(8'h22);
        slave_read(1'b0, d, a);
        vectors++;
        if (d !== 8'h07) begin
            miscompares++;
            $display("FAIL overrun_status: got %h expected 07", d);
        end
        slave_read(1'b0, d, a);
        vectors++;
        if (d !== 8'h03) begin
            miscompares++;
            $display("FAIL overrun_cleared: got %h expected 03", d);
        end
        slave_read(1'b1, d, a);
        vectors++;
        if (d !== 8'h22) begin
            miscompares++;
            $display("FAIL overrun_data: got %h expected 22", d);
        end
    endtask

    // A short low glitch and a byte with a bad stop bit must both be ignored.
    task automatic test_framing();
        logic [7:0] d;
        logic       a;
        @(posedge i_clk); #1;
        i_uart_rx = 1'b0;
        repeat (4) @(posedge i_clk);
        #1;
        i_uart_rx = 1'b1;
        repeat (40) @(posedge i_clk);
        send_byte(8'h44);
        send_byte(8'h77, 1'b0);
        send_byte(8'h99);
        slave_read(1'b0, d, a);
        vectors++;
        if (d !== 8'h03) begin
            miscompares++;
            $display("FAIL framing_status: got %h expected 03", d);
        end
        slave_read(1'b1, d, a);
        vectors++;
        if (d !== 8'h99) begin
            miscompares++;
            $display("FAIL framing_data: got %h expected 99", d);
        end
    endtask

    task automatic test_sys_reset();
        logic [7:0] d;
        logic       a;
        bit         seen = 1'b0;
        bit         quiet = 1'b1;
        int         high = 0;
        fork
            send_byte(8'h58);
            begin
                for (int i = 0; i < 400 && !seen; i++) begin
                    @(negedge i_clk);
                    if (o_reset === 1'b1) seen = 1'b1;
                end
                if (seen) begin
                    high = 1;
                    for (int i = 0; i < 20; i++) begin
                        @(negedge i_clk);
                        if (o_reset !== 1'b1) break;
                        high++;
                    end
                end
            end
        join
        vectors++;
        if (!seen || high != 4) begin
            miscompares++;
            $display("FAIL sysreset_pulse: got seen %b width %0d expected seen 1 width 4", seen, high);
        end
        for (int i = 0; i < 150; i++) begin
            @(negedge i_clk);
            if (o_uart_tx !== 1'b1) quiet = 1'b0;
        end
        vectors++;
        if (!quiet) begin
            miscompares++;
            $display("FAIL sysreset_no_reply: got activity on o_uart_tx expected idle");
        end
        fork
            capture_tx(8'h55, "cpu_tx");
            begin
                slave_write(1'b1, 8'h55);
                slave_read(1'b0, d, a);
                slave_write(1'b1, 8'hAA);
            end
        join
        vectors++;
        if (d !== 8'h00) begin
            miscompares++;
            $display("FAIL cpu_tx_busy_status: got %h expected 00", d);
        end
        quiet = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge i_clk);
            if (o_uart_tx !== 1'b1) quiet = 1'b0;
        end
        vectors++;
        if (!quiet) begin
            miscompares++;
            $display("FAIL cpu_tx_drop: got second frame expected busy write dropped");
        end
    endtask

    task automatic test_reset_abort();
        send_byte(8'h57); send_byte(8'h12);
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        send_byte(8'h34); send_byte(8'hAB);
        repeat (20) @(posedge i_clk);
        @(negedge i_clk);
        vectors++;
        if (o_master_cs !== 1'b0 || o_uart_tx !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_idle: got cs %b tx %b expected 0/1", o_master_cs, o_uart_tx);
        end
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h20); send_byte(8'hC3);
        wait_cs("abort_retry");
        vectors++;
        if ({o_master_we, o_master_addr, o_master_data} !== {1'b1, 16'h0020, 8'hC3}) begin
            miscompares++;
            $display("FAIL abort_retry_bus: got we %b addr %h data %h expected 1/0020/c3",
                     o_master_we, o_master_addr, o_master_data);
        end
        ack_bus("abort_retry", 8'h00);
        capture_tx(8'h4B, "abort_retry_reply");
    endtask

    initial begin
        i_reset = 1'b0;
        i_uart_rx = 1'b1;
        i_master_data = 8'h00;
        i_master_ack = 1'b0;
        i_slave_data = 8'h00;
        i_slave_addr = 1'b0;
        i_slave_we = 1'b0;
        i_slave_cs = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_deliver();
        test_overrun();
        test_framing();
        test_sys_reset();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_master_slave.md
UART_MASTER_SLAVE -- requirements
Module: uart_master_slave

Interface
REQ-001 SHALL have parameter BAUDRATE, default 1152000, serial bit rate in bits/s.
REQ-002 SHALL have parameter SYS_FREQ, default 25000000, i_clk frequency in Hz.
REQ-003 SHALL have port i_clk, input, 1 bit: single clock; all logic on rising edge.
REQ-004 SHALL have port i_reset, input, 1 bit: one clock, reset synchronous and active-low (0 = reset).
REQ-005 SHALL have port i_master_data, input, 8 bits: memory read data for master accesses.
REQ-006 SHALL have port o_master_data, output, 8 bits: memory write data.
REQ-007 SHALL have port o_master_addr, output, 16 bits: memory address.
REQ-008 SHALL have port i_master_ack, input, 1 bit: memory access complete.
REQ-009 SHALL have port o_master_we, output, 1 bit: 1 = write, 0 = read.
REQ-010 SHALL have port o_master_cs, output, 1 bit: master bus request.
REQ-011 SHALL have port i_slave_data, input, 8 bits: CPU write data.
REQ-012 SHALL have port o_slave_data, output, 8 bits: CPU read data.
REQ-013 SHALL have port i_slave_addr, input, 1 bit: 0 = status, 1 = data.
REQ-014 SHALL have port o_slave_ack, output, 1 bit: slave access acknowledge.
REQ-015 SHALL have ports i_slave_we and i_slave_cs, inputs, 1 bit each: CPU write strobe and select.
REQ-016 SHALL have port o_int, output, 1 bit: level interrupt request.
REQ-017 SHALL have ports i_uart_rx (input, 1 bit) and o_uart_tx (output, 1 bit): 8N1 serial lines.
REQ-018 SHALL have port o_reset, output, 1 bit: active-high system reset request.

Function
REQ-019 Bit period SHALL be DIV = SYS_FREQ/BAUDRATE clocks, integer truncation (defaults: 21).
REQ-020 RX SHALL double-flop i_uart_rx and detect a start bit on a falling edge.
REQ-021 RX SHALL recheck the start bit at DIV/2 and return to idle if it reads 1.
REQ-022 RX SHALL sample data bits LSB first at bit centres.
REQ-023 RX SHALL discard a byte whose stop bit reads 0.
REQ-024 TX SHALL send 8N1 LSB first and hold o_uart_tx=1 when idle.
REQ-025 Received bytes SHALL feed the command engine with states IDLE, GET_AH, GET_AL, GET_D, BUS, RESP.
REQ-026 Command 0x57 'W' SHALL take addrH, addrL and data, write memory, then transmit 0x4B 'K'.
REQ-027 Command 0x52 'R' SHALL take addrH and addrL, read memory, then transmit the read byte.
REQ-028 Command 0x58 'X' SHALL drive o_reset=1 for exactly 4 clocks, then return to IDLE with no reply.
REQ-029 Command 0x44 'D' SHALL take one byte and load it into the slave RX register.
REQ-030 Any other byte in IDLE SHALL be ignored.
REQ-031 In BUS, o_master_cs=1 with addr/we/data stable until the first cycle with i_master_ack=1.
REQ-032 Read data SHALL be captured in the ack cycle, and o_master_cs SHALL drop on the next clock.
REQ-033 Slave o_slave_ack SHALL equal i_slave_cs combinationally (zero wait).
REQ-034 o_slave_data SHALL be valid combinationally while i_slave_cs=1.
REQ-035 Status read (addr 0) SHALL return {5'b0, overrun, tx_ready, rx_valid}.
REQ-036 A status read SHALL clear overrun.
REQ-037 Data read (addr 1) SHALL return the RX register and clear rx_valid once per access, on the first cs cycle.
REQ-038 Data write (addr 1) with tx_ready=1 SHALL start a transmit; with tx_ready=0 the write SHALL be dropped.
REQ-039 A 'D' delivery while rx_valid=1 SHALL overwrite the RX register and set overrun.
REQ-040 Command responses SHALL have TX priority: a pending response is sent before a new slave write is accepted, and tx_ready=0 while a response is pending or sending.
REQ-041 o_int SHALL equal rx_valid.
REQ-042 'D' delivery and a data read in the same cycle SHALL leave rx_valid=1 with the new byte.

Reset
REQ-043 While i_reset=0: o_uart_tx=1, o_master_cs=0, o_master_we=0, o_master_addr=0, o_master_data=0, o_reset=0, o_int=0.
REQ-044 While i_reset=0, rx_valid, overrun and all counters SHALL be 0, and the engine SHALL be in IDLE.
REQ-045 Reset mid-frame or mid-BUS SHALL abort the operation with no reply.
REQ-046 o_reset SHALL NOT reset this block itself, so a host link survives a system reset.

Structure
REQ-047 Package uart_master_slave_pkg SHALL hold the command codes (0x57, 0x52, 0x58, 0x44), the reply code 0x4B, the status bit indices and the engine-state enum.
REQ-048 Sub-module uart_phy SHALL contain the baud divider, RX and TX, with byte valid/ready strobes.

Verification
REQ-049 Serial 0x57,0x12,0x34,0xAB -> o_master_cs=1, we=1, addr=0x1234, data=0xAB; ack after 3 clocks -> cs drops next clock; TX sends 0x4B.
REQ-050 Serial 0x52,0x00,0x10 with i_master_data=0x5A at ack -> TX sends 0x5A.
REQ-051 Serial 0x44,0x41 -> o_int=1; status read = 0x03; data read = 0x41 -> o_int=0.
REQ-052 Two 'D' bytes with no read -> status = 0x07, then 0x03 on the next status read.
REQ-053 Serial 0x58 -> o_reset high for exactly 4 clocks; a CPU write of 0x55 to addr 1 -> o_uart_tx start bit, 21 clocks/bit, 0x55 LSB first.
REQ-054 i_reset=0 mid-'W' after addrH -> no bus cycle, no reply; idle 0x57 frame afterwards is handled normally.
